// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
// Holds the FSM state encoding, requester ids and default bus widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic REQ_IFETCH = 1'b0;
    localparam logic REQ_DATA   = 1'b1;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick, purely combinational.
// On a tie the requester that was not served last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    // Single requester takes the port; a tie flips away from the last winner.
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = REQ_DATA;
        end else begin
            winner = REQ_IFETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Optional busy-cycle watchdog is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          done0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          gnt_sel,
    output logic          busy,
    output logic          err
);

    arb_state_e state, state_n;
    logic       last;
    logic       pick_valid;
    logic       pick_win;
    logic       grant;
    logic       ack_hit;
    logic       tmo_hit;
    logic       err_q;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_win)
    );

    assign grant   = (state == IDLE) && pick_valid;
    assign ack_hit = (state == BUSY) && mem_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;

    // A late ack on the final busy cycle still beats the watchdog.
    assign tmo_hit = (state == BUSY) && !mem_ack &&
                     (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count busy cycles; remember whether the transaction expired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (grant) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_q   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-state status outputs; DONE never arbitrates.
    always_comb begin
        state_n = state;
        done0   = 1'b0;
        done1   = 1'b0;
        busy    = 1'b0;
        err     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (ack_hit || tmo_hit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done0   = (gnt_sel == REQ_IFETCH);
                done1   = (gnt_sel == REQ_DATA);
                err     = err_q;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Latch the winner onto the memory side and capture the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            gnt_sel   <= 1'b0;
            rdata     <= '0;
            last      <= REQ_DATA;
        end else if (grant) begin
            mem_req   <= 1'b1;
            gnt_sel   <= pick_win;
            last      <= pick_win;
            mem_we    <= pick_win ? we1 : we0;
            mem_addr  <= pick_win ? addr1 : addr0;
            mem_wdata <= pick_win ? wdata1 : wdata0;
        end else if (ack_hit) begin
            rdata   <= mem_rdata;
            mem_req <= 1'b0;
        end else if (tmo_hit) begin
            rdata   <= '0;
            mem_req <= 1'b0;
        end
    end

endmodule
